// File: rtl/exmem_pipe_reg_if.sv
`default_nettype none
// ============================================================================
// Module   : exmem_pipe_reg_if
// Purpose  : EX->MEM stage bus: upstream valid/ready/payload from execute,
//            downstream valid/ready/payload toward memory.
// Revision : 1.0 - initial release
// ============================================================================
interface exmem_pipe_reg_if #(
  parameter int OPW   = 5,
  parameter int ADDRW = 7,
  parameter int DATAW = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [OPW-1:0]   in_opcode;
  logic [ADDRW-1:0] in_addr;
  logic [DATAW-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [OPW-1:0]   out_opcode;
  logic [ADDRW-1:0] out_addr;
  logic [DATAW-1:0] out_data;

  // Environment side: drives the execute payload and the memory-stage ready.
  modport master (
    output in_valid, in_opcode, in_addr, in_data, out_ready,
    input  in_ready, out_valid, out_opcode, out_addr, out_data
  );

  // Stage register side.
  modport slave (
    input  in_valid, in_opcode, in_addr, in_data, out_ready,
    output in_ready, out_valid, out_opcode, out_addr, out_data
  );
endinterface
`default_nettype wire

// File: rtl/exmem_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : exmem_pipe_reg
// Purpose  : EX/MEM pipeline register with valid/ready flow control, a
//            one-entry skid buffer, flush and NOP bubble insertion.
// Revision : 1.0 - initial release
// ============================================================================
module exmem_pipe_reg #(
  parameter int             OPW        = 5,
  parameter int             ADDRW      = 7,
  parameter int             DATAW      = 32,
  parameter logic [OPW-1:0] NOP_OPCODE = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  exmem_pipe_reg_if.slave bus
);

  // Encoding is {skid valid, main valid}; 2'b10 can never be reached.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [OPW-1:0]   m_op_q,   m_op_d;
  logic [ADDRW-1:0] m_addr_q, m_addr_d;
  logic [DATAW-1:0] m_data_q, m_data_d;
  logic [OPW-1:0]   s_op_q,   s_op_d;
  logic [ADDRW-1:0] s_addr_q, s_addr_d;
  logic [DATAW-1:0] s_data_q, s_data_d;

  logic w_m_valid;
  logic w_in_ready;
  logic w_accept;

  // in_ready comes straight from the state flops, so out_ready never
  // reaches it combinationally.
  assign w_m_valid  = state_q[0];
  assign w_in_ready = (state_q != ST_FULL);
  assign w_accept   = bus.in_valid & w_in_ready;

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = w_m_valid;
  assign bus.out_opcode = w_m_valid ? m_op_q : NOP_OPCODE;
  assign bus.out_addr   = m_addr_q;
  assign bus.out_data   = m_data_q;

  // Next-state and payload steering; flush overrides everything but leaves
  // the payload registers untouched.
  always_comb begin
    state_d  = state_q;
    m_op_d   = m_op_q;
    m_addr_d = m_addr_q;
    m_data_d = m_data_q;
    s_op_d   = s_op_q;
    s_addr_d = s_addr_q;
    s_data_d = s_data_q;
    case (state_q)
      ST_EMPTY: begin
        if (w_accept) begin
          m_op_d   = bus.in_opcode;
          m_addr_d = bus.in_addr;
          m_data_d = bus.in_data;
          state_d  = ST_ONE;
        end
      end
      ST_ONE: begin
        if (w_accept && bus.out_ready) begin
          m_op_d   = bus.in_opcode;
          m_addr_d = bus.in_addr;
          m_data_d = bus.in_data;
        end else if (w_accept) begin
          s_op_d   = bus.in_opcode;
          s_addr_d = bus.in_addr;
          s_data_d = bus.in_data;
          state_d  = ST_FULL;
        end else if (bus.out_ready) begin
          state_d  = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (bus.out_ready) begin
          m_op_d   = s_op_q;
          m_addr_d = s_addr_q;
          m_data_d = s_data_q;
          state_d  = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) begin
      state_d  = ST_EMPTY;
      m_op_d   = m_op_q;
      m_addr_d = m_addr_q;
      m_data_d = m_data_q;
      s_op_d   = s_op_q;
      s_addr_d = s_addr_q;
      s_data_d = s_data_q;
    end
  end

  // State and payload registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_EMPTY;
      m_op_q   <= '0;
      m_addr_q <= '0;
      m_data_q <= '0;
      s_op_q   <= '0;
      s_addr_q <= '0;
      s_data_q <= '0;
    end else begin
      state_q  <= state_d;
      m_op_q   <= m_op_d;
      m_addr_q <= m_addr_d;
      m_data_q <= m_data_d;
      s_op_q   <= s_op_d;
      s_addr_q <= s_addr_d;
      s_data_q <= s_data_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_exmem_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_exmem_pipe_reg
// Purpose  : Self-checking bench for exmem_pipe_reg (default and wide
//            parameter sets) against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exmem_pipe_reg;

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic flush  = 1'b0;
  logic flush2 = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  exmem_pipe_reg_if #(.OPW(5), .ADDRW(7), .DATAW(32)) bus ();
  exmem_pipe_reg_if #(.OPW(6), .ADDRW(12), .DATAW(64)) bus2 ();

  exmem_pipe_reg #(.OPW(5), .ADDRW(7), .DATAW(32), .NOP_OPCODE(5'b00000)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus)
  );

  exmem_pipe_reg #(.OPW(6), .ADDRW(12), .DATAW(64), .NOP_OPCODE(6'h3F)) dut2 (
    .clk(clk), .rst(rst), .flush(flush2), .bus(bus2)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  op;
    logic [6:0]  addr;
    logic [31:0] data;
  } ent_t;

  // Reference: FIFO of live entries (capacity 2) plus the last entry shown.
  ent_t q[$];
  ent_t shadow = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model update at each edge / reset.
  initial forever begin
    bit can_take;
    bit take_out;
    @(posedge clk or posedge rst);
    if (rst) begin
      q.delete();
      shadow = '0;
    end else if (flush) begin
      q.delete();
    end else begin
      can_take = (q.size() < 2);
      take_out = (q.size() > 0) && bus.out_ready;
      if (take_out) void'(q.pop_front());
      if (bus.in_valid && can_take) q.push_back({bus.in_opcode, bus.in_addr, bus.in_data});
    end
    if (q.size() > 0) shadow = q[0];
  end

  // Compare DUT against model every cycle, away from the active edge.
  initial forever begin
    @(negedge clk);
    chk("m_out_valid",  bus.out_valid,  q.size() > 0);
    chk("m_in_ready",   bus.in_ready,   q.size() < 2);
    chk("m_out_opcode", bus.out_opcode, (q.size() > 0) ? q[0].op : 5'd0);
    chk("m_out_addr",   bus.out_addr,   shadow.addr);
    chk("m_out_data",   bus.out_data,   shadow.data);
  end

  task automatic drive(input logic v, input logic [4:0] op, input logic [6:0] a, input logic [31:0] d);
    bus.in_valid  = v;
    bus.in_opcode = op;
    bus.in_addr   = a;
    bus.in_data   = d;
  endtask

  task automatic out_lit(input string tag, input logic v, input logic [4:0] op,
                         input logic [6:0] a, input logic [31:0] d);
    chk({tag, "_valid"},  bus.out_valid,  v);
    chk({tag, "_opcode"}, bus.out_opcode, op);
    chk({tag, "_addr"},   bus.out_addr,   a);
    chk({tag, "_data"},   bus.out_data,   d);
  endtask

  initial begin
    drive(1'b0, 5'd0, 7'd0, 32'd0);
    bus.out_ready   = 1'b0;
    bus2.in_valid   = 1'b0;
    bus2.in_opcode  = '0;
    bus2.in_addr    = '0;
    bus2.in_data    = '0;
    bus2.out_ready  = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    out_lit("rst", 1'b0, 5'd0, 7'd0, 32'd0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst2_opcode", bus2.out_opcode, 64'h3F);
    chk("rst2_valid", bus2.out_valid, 1'b0);
    rst = 1'b0;

    // Streaming back-to-back
    bus.out_ready = 1'b1;
    drive(1'b1, 5'd3, 7'h10, 32'hA5A5_0001);
    @(negedge clk);
    out_lit("str1", 1'b1, 5'd3, 7'h10, 32'hA5A5_0001);
    drive(1'b1, 5'd4, 7'h11, 32'hA5A5_0002);
    @(negedge clk);
    out_lit("str2", 1'b1, 5'd4, 7'h11, 32'hA5A5_0002);
    drive(1'b0, 5'd0, 7'd0, 32'd0);

    // Bubbles: NOP opcode, payload held
    repeat (3) begin
      @(negedge clk);
      out_lit("bub", 1'b0, 5'd0, 7'h11, 32'hA5A5_0002);
    end

    // Stall into skid, then drain in order
    drive(1'b1, 5'd1, 7'h1F, 32'h1111);
    @(negedge clk);
    out_lit("stl0", 1'b1, 5'd1, 7'h1F, 32'h1111);
    drive(1'b1, 5'd7, 7'h20, 32'h1234);
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("stl_in_ready_lo", bus.in_ready, 1'b0);
    out_lit("stl1", 1'b1, 5'd1, 7'h1F, 32'h1111);
    drive(1'b0, 5'd0, 7'd0, 32'd0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    out_lit("stl2", 1'b1, 5'd7, 7'h20, 32'h1234);
    chk("stl_in_ready_hi", bus.in_ready, 1'b1);
    @(negedge clk);
    chk("stl_empty", bus.out_valid, 1'b0);

    // Flush from FULL with a concurrent input
    bus.out_ready = 1'b0;
    drive(1'b1, 5'd5, 7'h30, 32'h5555);
    @(negedge clk);
    drive(1'b1, 5'd6, 7'h31, 32'h6666);
    @(negedge clk);
    chk("fl_full", bus.in_ready, 1'b0);
    drive(1'b1, 5'd9, 7'h39, 32'h9999);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    out_lit("fl1", 1'b0, 5'd0, 7'h30, 32'h5555);
    chk("fl_in_ready", bus.in_ready, 1'b1);
    drive(1'b0, 5'd0, 7'd0, 32'd0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("fl_gone", bus.out_valid, 1'b0);

    // Flush from ONE with an acceptable input: the input is discarded
    bus.out_ready = 1'b0;
    drive(1'b1, 5'd10, 7'h40, 32'hAAAA);
    @(negedge clk);
    drive(1'b1, 5'd11, 7'h41, 32'hBBBB);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    out_lit("fl2", 1'b0, 5'd0, 7'h40, 32'hAAAA);
    drive(1'b0, 5'd0, 7'd0, 32'd0);

    // Asynchronous reset while FULL
    drive(1'b1, 5'd12, 7'h50, 32'hC0C0);
    @(negedge clk);
    drive(1'b1, 5'd13, 7'h51, 32'hD0D0);
    @(negedge clk);
    chk("ar_full", bus.in_ready, 1'b0);
    drive(1'b0, 5'd0, 7'd0, 32'd0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    out_lit("ar", 1'b0, 5'd0, 7'd0, 32'd0);
    chk("ar_in_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic
    repeat (3000) begin
      @(negedge clk);
      drive($urandom_range(0, 3) != 0, 5'($urandom), 7'($urandom), $urandom);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 15) == 0);
    end
    @(negedge clk);
    drive(1'b0, 5'd0, 7'd0, 32'd0);
    flush = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Wide parameter set: bit-exact transfer and idle opcode
    bus2.out_ready = 1'b1;
    bus2.in_valid  = 1'b1;
    bus2.in_opcode = 6'h2A;
    bus2.in_addr   = 12'hFFF;
    bus2.in_data   = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    chk("w1_opcode", bus2.out_opcode, 64'h2A);
    chk("w1_addr",   bus2.out_addr,   64'hFFF);
    chk("w1_data",   bus2.out_data,   64'hFFFF_FFFF_FFFF_FFFF);
    bus2.in_opcode = 6'h15;
    bus2.in_addr   = 12'hAAA;
    bus2.in_data   = 64'hAAAA_AAAA_AAAA_AAAA;
    @(negedge clk);
    chk("w2_opcode", bus2.out_opcode, 64'h15);
    chk("w2_addr",   bus2.out_addr,   64'hAAA);
    chk("w2_data",   bus2.out_data,   64'hAAAA_AAAA_AAAA_AAAA);
    bus2.in_valid = 1'b0;
    @(negedge clk);
    chk("w3_valid",  bus2.out_valid,  1'b0);
    chk("w3_opcode", bus2.out_opcode, 64'h3F);
    chk("w3_data",   bus2.out_data,   64'hAAAA_AAAA_AAAA_AAAA);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/exmem_pipe_reg.md
# exmem_pipe_reg

Parametrised EX/MEM pipeline stage register with valid/ready flow control, a one-entry skid buffer, flush, and bubble (NOP) insertion. It sits between the ALU (execute) stage and the memory stage. It carries opcode, current instruction address and ALU result. It adds stall backpressure and squash behaviour that the plain clocked stage register lacks. All state is updated on the rising edge only; there is no negedge capture.

## Interface
- OPW, 5, opcode width
- ADDRW, 7, instruction address width
- DATAW, 32, ALU result width
- NOP_OPCODE, 5'b00000, opcode driven on out_opcode whenever out_valid=0 (width OPW)
- clk  in  1  stage clock, rising-edge active
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  squash all held entries (branch taken / exception)
- in_valid  in  1  execute stage presents an instruction
- in_ready  out  1  stage can accept; equals !skid_valid (registered, no combinational path from out_ready)
- in_opcode  in  OPW  opcode from EX
- in_addr  in  ADDRW  current address from EX
- in_data  in  DATAW  ALU result from EX
- out_valid  out  1  main register holds a live instruction
- out_ready  in  1  memory stage accepts this cycle
- out_opcode  out  OPW  opcode to MEM; NOP_OPCODE when out_valid=0
- out_addr  out  ADDRW  address to MEM
- out_data  out  DATAW  ALU result to MEM

## Operation
- Storage: main register (m_valid, m_op, m_addr, m_data) drives outputs; skid register (s_valid, s_op, s_addr, s_data) holds one overflow entry.
- Transfers: accept = in_valid & in_ready; drain = m_valid & out_ready; m_free = !m_valid | out_ready.
- States are encoded by {s_valid, m_valid}: EMPTY (00), ONE (01), FULL (11). State 10 is unreachable.
- EMPTY: on accept, load main and go to ONE.
- ONE:
  - accept & m_free: main reloads from input; stays ONE.
  - accept & !out_ready: input goes to skid; goes to FULL.
  - drain & !accept: goes to EMPTY.
  - otherwise hold.
- FULL: in_ready=0. On out_ready, skid moves to main, s_valid clears, and the state goes to ONE. Otherwise hold both.
- Ordering: entries leave in acceptance order; skid contents always leave before any newer input.
- Flush: m_valid and s_valid both clear at the next edge. A concurrent accept is discarded, so flush wins. Payload registers keep their values. The output opcode becomes NOP_OPCODE immediately through the valid gating.
- Bubble: out_opcode = m_valid ? m_op : NOP_OPCODE. out_addr and out_data show held contents regardless of valid.
- Width rules: fields pass through unmodified, with no extension or truncation. NOP_OPCODE must fit in OPW bits.

## Timing
- Reset (async assert, released synchronously by the system):
  - m_valid=0, s_valid=0, so out_valid=0 and in_ready=1.
  - out_opcode=NOP_OPCODE, out_addr=0, out_data=0; skid payload=0.
- Latency: an input accepted at edge N appears on outputs after edge N, i.e. 1 cycle, when the stage was EMPTY or draining.
- Throughput: 1 entry/cycle while out_ready=1.
- Backpressure: in_ready falls one cycle after the first stalled accept and rises the cycle after the skid drains. The upstream stage may therefore lose no data even though it samples in_ready registered.
- Simultaneous flush + rst: rst dominates. rst asserted mid-transfer discards all entries immediately, with no edge required.
- out_ready toggling while out_valid=0 has no effect.
- Inputs must be stable around the rising edge of clk (setup/hold of the capture flops).

## Test plan
- Reset: assert rst mid-stream with FULL state -> out_valid=0, in_ready=1, out_opcode=NOP_OPCODE, out_addr=0, out_data=0 without waiting for clk.
- Streaming: out_ready=1, feed op=3/addr=0x10/data=0xA5A5_0001 then op=4/addr=0x11/data=0xA5A5_0002 on consecutive cycles -> each appears one cycle later, back-to-back, out_valid=1 both cycles.
- Stall with skid: out_ready=0 while in ONE, accept op=7/addr=0x20/data=0x1234 -> in_ready=0 next cycle, outputs keep the older entry. Raise out_ready -> older entry drains, then 0x1234 entry, in order, then in_ready=1.
- Flush: FULL state plus flush=1 with in_valid=1 -> next cycle out_valid=0, out_opcode=NOP_OPCODE, in_ready=1, and the flushed input is never seen at the output.
- Bubble: in_valid=0 for 3 cycles with out_ready=1 -> out_valid=0 and out_opcode=NOP_OPCODE for those cycles; out_data holds the last value.
- Parameter sweep: OPW=6, ADDRW=12, DATAW=64, NOP_OPCODE=6'h3F -> full-width values (all-ones, alternating 0xAAAA…) pass bit-exact; the idle opcode reads 0x3F.
